// File: rtl/ula_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: ULA op codes, MULDIV op codes, FSM states.
package ula_muldiv_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREP1,
    ST_PREP2,
    ST_ITER,
    ST_FIX1,
    ST_FIX2,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ula_muldiv_sequencer_step.sv
// One shift-add multiply or restoring-divide step: derives carry/borrow from MSBs and forms the next {hi,lo}.
module ula_muldiv_sequencer_step
  import ula_muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] alu_output,
  input  logic                  m_msb,
  output logic [DATA_WIDTH-1:0] next_hi,
  output logic [DATA_WIDTH-1:0] next_lo
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] rem;
  logic         b_msb;
  logic         carry;
  logic         borrow;
  logic         take;

  always_comb begin
    rem     = {hi[W-2:0], lo[W-1]};
    b_msb   = lo[0] & m_msb;
    carry   = (hi[W-1] & b_msb) | ((hi[W-1] | b_msb) & ~alu_output[W-1]);
    borrow  = (~rem[W-1] & m_msb) | (~(rem[W-1] ^ m_msb) & alu_output[W-1]);
    // The bit shifted out of hi means the partial remainder already exceeds any divisor.
    take    = hi[W-1] | ~borrow;
    next_hi = {carry, alu_output[W-1:1]};
    next_lo = {alu_output[0], lo[W-1:1]};
    if (is_div) begin
      next_hi = take ? alu_output : rem;
      next_lo = {lo[W-2:0], take};
    end
  end

endmodule

// File: rtl/ula_muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO, stepping an external ULA one op per cycle.
// Signed MULT/DIV are built only when MULDIV_SIGNED_EN is defined; otherwise Op[1] is ignored.
module ula_muldiv_sequencer
  import ula_muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hi_write,
  input  logic                  lo_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] alu_output,
  input  logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] alu_data1,
  output logic [DATA_WIDTH-1:0] alu_data2,
  output logic [3:0]            alu_control,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W      = DATA_WIDTH;
  localparam int STEP_W = $clog2(DATA_WIDTH);
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic [W-1:0]      m;
  logic              is_div;
  logic              is_signed;
  logic              sign_a;
  logic              sign_b;
  logic [W-1:0]      next_hi;
  logic [W-1:0]      next_lo;
  logic [W-1:0]      src_b;
  logic [W-1:0]      init_m;
  logic [W-1:0]      init_lo;

  // ULA operands are registered, so each edge drives the operands for the step that follows it.
  function automatic logic [W-1:0] drive1(input logic div, input logic [W-1:0] h, input logic [W-1:0] l);
    return div ? {h[W-2:0], l[W-1]} : h;
  endfunction

  function automatic logic [W-1:0] drive2(input logic div, input logic [W-1:0] l, input logic [W-1:0] d);
    return (div || l[0]) ? d : '0;
  endfunction

  ula_muldiv_sequencer_step #(.DATA_WIDTH(W)) u_step (
    .is_div     (is_div),
    .hi         (hi),
    .lo         (lo),
    .alu_output (alu_output),
    .m_msb      (m[W-1]),
    .next_hi    (next_hi),
    .next_lo    (next_lo)
  );

  always_comb begin
    src_b   = (state == ST_PREP2 && op_b[W-1]) ? alu_output : op_b;
    init_m  = is_div ? src_b : op_a;
    init_lo = is_div ? op_a : src_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      step        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      m           <= '0;
      is_div      <= 1'b0;
      is_signed   <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_control <= ALU_AND;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a      <= operand_a;
            op_b      <= operand_b;
            is_div    <= op[0];
            is_signed <= op[1] & SIGNED_EN;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end else begin
            if (hi_write) hi <= write_data;
            if (lo_write) lo <= write_data;
          end
        end
        ST_LOAD, ST_PREP2: begin
          if (state == ST_LOAD && is_signed) begin
            alu_data1   <= '0;
            alu_data2   <= op_a;
            alu_control <= ALU_SUB;
            state       <= ST_PREP1;
          end else begin
            if (state == ST_PREP2) sign_b <= op_b[W-1];
            hi          <= '0;
            lo          <= init_lo;
            m           <= init_m;
            alu_data1   <= drive1(is_div, '0, init_lo);
            alu_data2   <= drive2(is_div, init_lo, init_m);
            alu_control <= is_div ? ALU_SUB : ALU_ADD;
            step        <= '0;
            state       <= ST_ITER;
          end
        end
        ST_PREP1: begin
          sign_a <= op_a[W-1];
          if (op_a[W-1]) op_a <= alu_output;
          alu_data1   <= '0;
          alu_data2   <= op_b;
          alu_control <= ALU_SUB;
          state       <= ST_PREP2;
        end
        ST_ITER: begin
          hi   <= next_hi;
          lo   <= next_lo;
          step <= step + 1'b1;
          if (step == STEP_W'(W - 1)) begin
            if (is_signed) begin
              alu_data1   <= '0;
              alu_data2   <= next_lo;
              alu_control <= ALU_SUB;
              state       <= ST_FIX1;
            end else begin
              busy        <= 1'b0;
              done        <= 1'b1;
              alu_data1   <= '0;
              alu_data2   <= '0;
              alu_control <= ALU_AND;
              state       <= ST_DONE;
            end
          end else begin
            alu_data1 <= drive1(is_div, next_hi, next_lo);
            alu_data2 <= drive2(is_div, next_lo, m);
          end
        end
        ST_FIX1: begin
          if (sign_a ^ sign_b) lo <= alu_output;
          // A product's high word borrows only when the low word negated to zero.
          if (is_div ? sign_a : ((sign_a ^ sign_b) && alu_zero)) begin
            alu_data1   <= '0;
            alu_data2   <= hi;
            alu_control <= ALU_SUB;
          end else if (!is_div && (sign_a ^ sign_b)) begin
            alu_data1   <= hi;
            alu_data2   <= hi;
            alu_control <= ALU_NOR;
          end else begin
            alu_data1   <= hi;
            alu_data2   <= '0;
            alu_control <= ALU_ADD;
          end
          state <= ST_FIX2;
        end
        ST_FIX2: begin
          if (is_div ? sign_a : (sign_a ^ sign_b)) hi <= alu_output;
          busy        <= 1'b0;
          done        <= 1'b1;
          alu_data1   <= '0;
          alu_data2   <= '0;
          alu_control <= ALU_AND;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv_sequencer.sv
// Self-checking bench for ula_muldiv_sequencer with a behavioural ULA and an arithmetic HI/LO reference model.
module tb_ula_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         hi_write = 1'b0;
  logic         lo_write = 1'b0;
  logic [W-1:0] write_data = '0;
  logic [W-1:0] alu_output;
  logic         alu_zero;
  logic [W-1:0] alu_data1;
  logic [W-1:0] alu_data2;
  logic [3:0]   alu_control;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .write_data  (write_data),
    .alu_output  (alu_output),
    .alu_zero    (alu_zero),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_control (alu_control),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  // External ULA the sequencer drives while busy.
  always_comb begin
    alu_output = '0;
    case (alu_control)
      4'b0000: alu_output = alu_data1 & alu_data2;
      4'b0010: alu_output = alu_data1 + alu_data2;
      4'b0110: alu_output = alu_data1 - alu_data2;
      4'b1100: alu_output = ~(alu_data1 | alu_data2);
      default: alu_output = '0;
    endcase
    alu_zero = (alu_output == '0);
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    logic           sgn;
    logic [W-1:0]   ma, mb, q, r;
    logic [2*W-1:0] p;
    sgn = SIGNED_EN && o[1];
    ma  = (sgn && a[W-1]) ? -a : a;
    mb  = (sgn && b[W-1]) ? -b : b;
    if (!o[0]) begin
      p = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
      if (sgn && (a[W-1] ^ b[W-1])) p = -p;
      eh = p[2*W-1:W];
      el = p[W-1:0];
    end else begin
      if (mb == '0) begin
        q = '1;
        r = ma;
      end else begin
        q = ma / mb;
        r = ma % mb;
      end
      if (sgn && (a[W-1] ^ b[W-1])) q = -q;
      if (sgn && a[W-1]) r = -r;
      eh = r;
      el = q;
    end
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int n;
    int lat;
    model(o, a, b, eh, el);
    lat = (SIGNED_EN && o[1]) ? W + 5 : W + 1;
    issue(o, a, b);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    int n;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_alu_control", alu_control, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_and_check("multu_200_44", 2'b00, 32'd200, 32'd44);
    check("multu_200_44_lo_const", lo, 32'h0000_2260);
    run_and_check("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    run_and_check("divu_200_44", 2'b01, 32'd200, 32'd44);
    check("divu_200_44_lo_const", lo, 32'd4);
    check("divu_200_44_hi_const", hi, 32'd24);
    run_and_check("divu_by_zero", 2'b01, 32'h1234, 32'd0);
    check("divu_by_zero_lo_const", lo, 32'hFFFF_FFFF);
    check("divu_by_zero_hi_const", hi, 32'h1234);

    // Start and LoWrite while busy are both ignored.
    issue(2'b00, 32'd200, 32'd44);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start      = 1'b1;
    op         = 2'b01;
    operand_a  = 32'd999;
    operand_b  = 32'd7;
    lo_write   = 1'b1;
    write_data = 32'hAA;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lo_write = 1'b0;
    check("busy_start_ignored", busy, 1);
    wait_done(n);
    check("busy_start_latency", 64'(n), 64'(W + 1 - 5));
    check("busy_start_lo", lo, 32'h0000_2260);
    check("busy_start_hi", hi, 32'h0);

    // Start held through DONE is only taken once back in IDLE.
    start     = 1'b1;
    op        = 2'b01;
    operand_a = 32'd200;
    operand_b = 32'd44;
    @(posedge clk);
    #1;
    check("start_in_done_ignored", busy, 0);
    check("done_dropped", done, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_after_done_accepted", busy, 1);
    wait_done(n);
    check("restart_latency", 64'(n), 64'(W + 1));
    check("restart_lo", lo, 32'd4);
    check("restart_hi", hi, 32'd24);
    @(posedge clk);
    #1;

    @(negedge clk);
    lo_write   = 1'b1;
    write_data = 32'hAA;
    @(posedge clk);
    #1;
    lo_write = 1'b0;
    check("idle_lo_write", lo, 32'hAA);
    @(negedge clk);
    hi_write   = 1'b1;
    write_data = 32'h55;
    @(posedge clk);
    #1;
    hi_write = 1'b0;
    check("idle_hi_write", hi, 32'h55);

    // Asynchronous reset in the middle of an operation.
    issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midop_reset_busy", busy, 0);
    check("midop_reset_done", done, 0);
    check("midop_reset_hi", hi, 0);
    check("midop_reset_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after_reset_divu", 2'b01, 32'd1000, 32'd7);

`ifdef MULDIV_SIGNED_EN
    run_and_check("mult_m7_3", 2'b10, -32'sd7, 32'sd3);
    check("mult_m7_3_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_m7_3_lo_const", lo, 32'hFFFF_FFEB);
    run_and_check("div_m7_2", 2'b11, -32'sd7, 32'sd2);
    check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
    run_and_check("mult_neg_zero_low", 2'b10, 32'h8000_0000, 32'hFFFF_FFFE);
`endif

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = $urandom_range(1, 100);
      if (i == 7) rb = '0;
      run_and_check($sformatf("random_%0d", i), ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
